line_buf_fifo: RTL and testbench

Ready/valid FIFO controller that owns the 64×512 single-read/single-write SRAM macro `array_19_ext` and turns it into a streaming queue. It sits directly upstream of that macro: it drives the write port, issues reads, and absorbs the macro's one-cycle registered-address read latency with a 2-entry output staging buffer. Consumers see zero-bubble dequeue.

---
 rtl/line_buf_fifo_pkg.sv | 13 +
 rtl/array_19_ext.sv | 31 +++
 rtl/line_buf_fifo.sv | 126 ++++++++++++
 tb/tb_line_buf_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_fifo_pkg.sv
// Shared constants and types for the line_buf_fifo streaming queue.
package line_buf_fifo_pkg;

    localparam int unsigned LBF_ADDR_W    = 6;
    localparam int unsigned LBF_DATA_W    = 512;
    localparam int unsigned LBF_DEPTH     = 64;
    localparam int unsigned LBF_STG_DEPTH = 2;
    localparam int unsigned LBF_CAP       = LBF_DEPTH + LBF_STG_DEPTH;

    typedef logic [LBF_ADDR_W-1:0] lbf_ptr_t;
    typedef logic [LBF_ADDR_W:0]   lbf_cnt_t;

endpackage

// File: rtl/array_19_ext.sv
// Behavioural model of the 64x512 1R1W SRAM macro: registered read address,
// read data valid the cycle after R0_en, write on the W0_clk edge.
module array_19_ext (
    input  logic [5:0]   R0_addr,
    input  logic         R0_en,
    input  logic         R0_clk,
    output logic [511:0] R0_data,
    input  logic [5:0]   W0_addr,
    input  logic         W0_en,
    input  logic         W0_clk,
    input  logic [511:0] W0_data
);

    logic [511:0] ram [0:63];
    logic [5:0]   raddr_q;

    always_ff @(posedge R0_clk) begin
        if (R0_en) begin
            raddr_q <= R0_addr;
        end
    end

    always_ff @(posedge W0_clk) begin
        if (W0_en) begin
            ram[W0_addr] <= W0_data;
        end
    end

    assign R0_data = ram[raddr_q];

endmodule

// File: rtl/line_buf_fifo.sv
// Ready/valid FIFO around the array_19_ext SRAM with a 2-entry output staging buffer.
// Optional empty-path bypass into staging: define LINE_BUF_FIFO_BYPASS_EN.
module line_buf_fifo
    import line_buf_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = LBF_DATA_W,
    parameter int unsigned ADDR_W = LBF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CAP   = (1 << ADDR_W) + LBF_STG_DEPTH;

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   mem_cnt;
    logic [1:0]        stg_cnt;
    logic              rd_inflight;
    logic [DATA_W-1:0] stg_head;
    logic [DATA_W-1:0] stg_tail;

    logic              enq_fire;
    logic              deq_fire;
    logic              bypass;
    logic              wr_en;
    logic              rd_en;
    logic              fill;
    logic [1:0]        stg_left;
    logic [2:0]        stg_pending;
    logic [DATA_W-1:0] fill_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] head_n;
    logic [DATA_W-1:0] tail_n;
    logic [1:0]        stg_cnt_n;
    logic [ADDR_W:0]   mem_cnt_n;
    logic [ADDR_W:0]   count_n;

    // Next-state: handshakes, write/bypass steering, read issue and staging update.
    always_comb begin
        enq_fire    = enq_valid && enq_ready;
        deq_fire    = deq_valid && deq_ready;
        stg_left    = stg_cnt - 2'(deq_fire);
        stg_pending = 3'(stg_cnt) + 3'(rd_inflight) - 3'(deq_fire);
`ifdef LINE_BUF_FIFO_BYPASS_EN
        // Only bypass when no older word sits in SRAM or is in flight.
        bypass      = enq_fire && (mem_cnt == '0) && !rd_inflight && (stg_left < 2'd2);
`else
        bypass      = 1'b0;
`endif
        wr_en       = enq_fire && !bypass;
        // Pre-write mem_cnt: a word written this cycle is never read this cycle.
        rd_en       = (mem_cnt != '0) && (stg_pending < 3'd2);
        fill        = rd_inflight || bypass;
        fill_data   = rd_inflight ? rd_data : enq_bits;

        head_n = stg_head;
        tail_n = stg_tail;
        if (deq_fire) begin
            head_n = stg_tail;
        end
        if (fill) begin
            if (stg_left == 2'd0) begin
                head_n = fill_data;
            end else begin
                tail_n = fill_data;
            end
        end

        stg_cnt_n = stg_left + 2'(fill);
        mem_cnt_n = mem_cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
        count_n   = count + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_cnt     <= '0;
            stg_cnt     <= '0;
            rd_inflight <= 1'b0;
            count       <= '0;
            enq_ready   <= 1'b1;
            deq_valid   <= 1'b0;
            stg_head    <= '0;
            stg_tail    <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rptr <= rptr + ADDR_W'(1);
            end
            mem_cnt     <= mem_cnt_n;
            stg_cnt     <= stg_cnt_n;
            rd_inflight <= rd_en;
            count       <= count_n;
            enq_ready   <= (count_n != CNT_W'(CAP));
            deq_valid   <= (stg_cnt_n != 2'd0);
            stg_head    <= head_n;
            stg_tail    <= tail_n;
        end
    end

    assign deq_bits = stg_head;

    array_19_ext u_ram (
        .R0_addr (rptr),
        .R0_en   (rd_en),
        .R0_clk  (clock),
        .R0_data (rd_data),
        .W0_addr (wptr),
        .W0_en   (wr_en),
        .W0_clk  (clock),
        .W0_data (enq_bits)
    );

endmodule

// File: tb/tb_line_buf_fifo.sv
// Directed self-checking bench for line_buf_fifo (works with or without LINE_BUF_FIFO_BYPASS_EN).
module tb_line_buf_fifo;
    import line_buf_fifo_pkg::*;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned ADDR_W = 6;
`ifdef LINE_BUF_FIFO_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 3;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_bits;
    logic              deq_valid;
    logic              deq_ready;
    logic [DATA_W-1:0] deq_bits;
    logic [ADDR_W:0]   count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       ev;
        logic [7:0] eb;
        logic       dr;
        logic       er;
        logic       dv;
        lbf_cnt_t   cnt;
        logic [7:0] bits;
    } vec_t;

    vec_t vecs [9];

    line_buf_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .count     (count)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] pat(input int unsigned v);
        return {16{v}};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_dv(input int max_cycles);
        int waited;
        waited = 0;
        while (!deq_valid && waited < max_cycles) begin
            step();
            waited++;
        end
    endtask

    // Pop one word (deq_ready must be high) and compare it.
    task automatic pop_expect(input string name, input logic [DATA_W-1:0] req);
        wait_dv(8);
        check({name, "_valid"}, DATA_W'(deq_valid), DATA_W'(1));
        check({name, "_bits"}, deq_bits, req);
        step();
    endtask

    initial begin
        reset     = 1'b1;
        enq_valid = 1'b0;
        enq_bits  = '0;
        deq_ready = 1'b0;

`ifdef LINE_BUF_FIFO_BYPASS_EN
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 7'd1, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd0, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd0, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd0, 8'h00};
        vecs[4] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 7'd1, 8'h11};
        vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 7'd2, 8'h11};
`else
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 7'd1, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd1, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd1, 8'hA5};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd0, 8'h00};
        vecs[4] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 7'd1, 8'h00};
        vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 7'd2, 8'h00};
`endif
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 7'd2, 8'h11};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd1, 8'h22};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd0, 8'h00};

        step();
        step();
        check("rst_enq_ready", DATA_W'(enq_ready), DATA_W'(1));
        check("rst_deq_valid", DATA_W'(deq_valid), DATA_W'(0));
        check("rst_count", DATA_W'(count), DATA_W'(0));
        check("rst_deq_bits", deq_bits, '0);
        reset = 1'b0;

        // Table: single word through the empty FIFO, then two back-to-back words.
        for (int i = 0; i < 9; i++) begin
            enq_valid = vecs[i].ev;
            enq_bits  = DATA_W'(vecs[i].eb);
            deq_ready = vecs[i].dr;
            step();
            check($sformatf("vec%0d_enq_ready", i), DATA_W'(enq_ready), DATA_W'(vecs[i].er));
            check($sformatf("vec%0d_deq_valid", i), DATA_W'(deq_valid), DATA_W'(vecs[i].dv));
            check($sformatf("vec%0d_count", i), DATA_W'(count), DATA_W'(vecs[i].cnt));
            if (vecs[i].dv) begin
                check($sformatf("vec%0d_deq_bits", i), deq_bits, DATA_W'(vecs[i].bits));
            end
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;

        // Empty-FIFO latency.
        begin
            int lat;
            enq_valid = 1'b1;
            enq_bits  = pat(32'h5A);
            step();
            enq_valid = 1'b0;
            lat = 1;
            while (!deq_valid && lat < 10) begin
                step();
                lat++;
            end
            check("empty_latency", DATA_W'(lat), DATA_W'(EXP_LAT));
            deq_ready = 1'b1;
            pop_expect("latency_word", pat(32'h5A));
            deq_ready = 1'b0;
        end

        // Fill: 70 offered, 66 accepted.
        for (int i = 0; i < 70; i++) begin
            enq_valid = 1'b1;
            enq_bits  = pat(i);
            check($sformatf("fill%0d_enq_ready", i), DATA_W'(enq_ready), DATA_W'(i < LBF_CAP));
            check($sformatf("fill%0d_count", i), DATA_W'(count), DATA_W'((i < LBF_CAP) ? i : LBF_CAP));
            step();
        end
        check("full_count", DATA_W'(count), DATA_W'(LBF_CAP));
        check("full_enq_ready", DATA_W'(enq_ready), DATA_W'(0));

        // Full with simultaneous enq and deq: only the dequeue fires.
        enq_bits  = pat(1000);
        deq_ready = 1'b1;
        check("full_head_bits", deq_bits, pat(0));
        step();
        enq_valid = 1'b0;
        check("full_deq_count", DATA_W'(count), DATA_W'(LBF_CAP - 1));
        check("full_deq_enq_ready", DATA_W'(enq_ready), DATA_W'(1));
        for (int k = 1; k < 66; k++) begin
            pop_expect($sformatf("drain%0d", k), pat(k));
        end
        check("drain_empty_count", DATA_W'(count), DATA_W'(0));
        check("drain_empty_valid", DATA_W'(deq_valid), DATA_W'(0));

        // Prime 10, then stream 200 at one word per cycle across pointer wraps.
        deq_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enq_valid = 1'b1;
            enq_bits  = pat(2000 + i);
            step();
        end
        enq_valid = 1'b0;
        step();
        step();
        step();
        deq_ready = 1'b1;
        for (int j = 0; j < 200; j++) begin
            enq_valid = 1'b1;
            enq_bits  = pat(2010 + j);
            if (!(deq_valid && enq_ready && deq_bits == pat(2000 + j))) begin
                check($sformatf("stream%0d_bits", j), deq_bits, pat(2000 + j));
                check($sformatf("stream%0d_valid", j), DATA_W'(deq_valid), DATA_W'(1));
            end else begin
                check($sformatf("stream%0d", j), deq_bits, pat(2000 + j));
            end
            step();
        end
        enq_valid = 1'b0;
        check("stream_count", DATA_W'(count), DATA_W'(10));
        for (int k = 200; k < 210; k++) begin
            pop_expect($sformatf("stream_tail%0d", k), pat(2000 + k));
        end
        check("stream_empty", DATA_W'(count), DATA_W'(0));

        // Reset during an in-flight SRAM read.
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_bits  = pat(3000 + i);
            step();
        end
        enq_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("pre_reset_count", DATA_W'(count), DATA_W'(2));
        reset = 1'b1;
        #1;
        check("midrst_deq_valid", DATA_W'(deq_valid), DATA_W'(0));
        check("midrst_count", DATA_W'(count), DATA_W'(0));
        check("midrst_enq_ready", DATA_W'(enq_ready), DATA_W'(1));
        step();
        reset = 1'b0;
        enq_valid = 1'b1;
        enq_bits  = pat(1);
        deq_ready = 1'b1;
        step();
        enq_valid = 1'b0;
        pop_expect("post_reset_first", pat(1));
        check("post_reset_count", DATA_W'(count), DATA_W'(0));
        check("post_reset_valid", DATA_W'(deq_valid), DATA_W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
